// File: rtl/rom_stream_reader.sv
// Read-side sequencer for a synchronous ROM with a 1-cycle registered read.
// Walks a block of consecutive addresses and streams the words out through a
// 2-entry buffer. Reads are only issued while buffered + in-flight words
// (less any word leaving this cycle) stay below 2, so the buffer can never
// overflow and a full-rate stream still sees one word per cycle.
module rom_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DEPTH_LOG-1:0] base_addr,
  input  logic [DEPTH_LOG:0]   length,
  output logic [DEPTH_LOG-1:0] addr_rd,
  output logic                 rd_issue,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = DEPTH_LOG + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_LOG-1:0] base_q, base_d;
  logic [CW-1:0]        len_q, len_d;
  logic [CW-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]        pop_cnt_q, pop_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
  logic [DEPTH_LOG-1:0] last_addr_q, last_addr_d;
  logic                 done_q, done_d;

  logic                 pop_now;
  logic                 credit_ok;
  logic [2:0]           occ;
  logic [CW-1:0]        addr_sum, addr_wrap;
  logic [DEPTH_LOG-1:0] next_addr;

  // Stream side, credit check and wrapped read address.
  always_comb begin
    out_valid = (cnt_q != 2'd0);
    out_data  = buf0_q;
    pop_now   = out_valid & out_ready;
    occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_now};
    credit_ok = (occ < 3'd2);
    rd_issue  = (state_q == RUN) & (issue_cnt_q < len_q) & credit_ok;
    addr_sum  = {1'b0, base_q} + issue_cnt_q;
    addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;
    next_addr = addr_wrap[DEPTH_LOG-1:0];
    // Address holds its last issued value between reads.
    addr_rd   = rd_issue ? next_addr : last_addr_q;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

  // Next-state: FSM, block counters and the 2-entry shift buffer.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    inflight_d  = rd_issue;
    last_addr_d = last_addr_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            base_d      = base_addr;
            len_d       = length;
            issue_cnt_d = '0;
            pop_cnt_d   = '0;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN:   if (issue_cnt_q == len_q) state_d = DRAIN;
      DRAIN: begin
        if (pop_cnt_q == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_issue) begin
      issue_cnt_d = issue_cnt_q + CW'(1);
      last_addr_d = next_addr;
    end
    if (pop_now) pop_cnt_d = pop_cnt_q + CW'(1);

    // Word from last cycle's read lands at the tail; head leaves on pop.
    case ({inflight_q, pop_now})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = data_in;
        else               buf1_d = data_in;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) buf0_d = data_in;
        else begin
          buf0_d = buf1_q;
          buf1_d = data_in;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset discards any block in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      last_addr_q <= '0;
      done_q      <= 1'b0;
      cnt_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= inflight_d;
      last_addr_q <= last_addr_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

endmodule
